load_store_unit: RTL
====================

# load_store_unit

Multicycle data-memory access unit downstream of the control FSM: consumes the memory-read and memory-write strobes issued in the MEMREAD/MEMWR states, drives a req/ack memory port, and returns an aligned, extended load word for MEMWB. Handles byte/half/word lanes, misalignment and timeout detection, and stalls the controller via `busy` until the access completes.

## Interface
- `TIMEOUT`, 255: max REQ cycles waiting for `mem_ack`; 0 disables the timeout.
- `clk`  in  1  clock; all state updates on rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `start_rd`  in  1  one-cycle load request (MEMREAD state).
- `start_wr`  in  1  one-cycle store request (MemWrite).
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  32  byte address from the address register.
- `wdata`  in  32  store data (rs2).
- `busy`  out  1  controller must hold its state while high.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  access failed; valid with `done`, held until next start.
- `rdata`  out  32  extended load result; held until next successful load.
- `mem_req`  out  1  memory request, held until ack.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word address (`addr[31:2]`, low bits 00).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables.
- `mem_ack`  in  1  memory accepted/completed; read data valid same cycle.
- `mem_rdata`  in  32  read word.

## Operation
- States: IDLE, REQ, DONE.
- IDLE: on `start_rd` xor `start_wr`, latch `addr`, `funct3`, `wdata`, direction; run checks; go REQ (checks pass) or DONE with fault (checks fail). Both starts high: fault, no access.
- Checks: H/HU need `addr[0]`=0; W needs `addr[1:0]`=00; funct3 011/110/111 illegal; store with funct3[2]=1 illegal.
- REQ: `mem_req`=1, `mem_we`/`mem_addr`/`mem_wdata`/`mem_be` stable from latched values. Cycle counter increments each REQ cycle without ack. On `mem_ack`: loads capture extended data into `rdata`; go DONE. Counter reaching `TIMEOUT` without ack: fault, drop req, go DONE.
- DONE: `done`=1 for one cycle, `busy`=0, return to IDLE.
- Byte enables: B `0001<<addr[1:0]`; H `0011<<{addr[1],1'b0}`; W `1111`.
- Store data: B `{4{wdata[7:0]}}`; H `{2{wdata[15:0]}}`; W unchanged.
- Load data: select lane by `addr[1:0]`, sign-extend (B/H) or zero-extend (BU/HU) to 32 bits.
- Faulted access: no memory traffic, `rdata` unchanged.
- `fault` cleared on the next accepted start.
- Starts arriving outside IDLE are ignored.

## Timing
- Reset: state IDLE; `busy`, `done`, `fault`, `mem_req`, `mem_we` = 0; `rdata`, `mem_addr`, `mem_wdata` = 0; `mem_be` = 0000; counter = 0.
- `resetn` low mid-access: IDLE next edge, `mem_req` drops; a later `mem_ack` is ignored.
- `busy` = start (combinational) OR state==REQ; goes high in the start cycle so the controller freezes immediately.
- Start at cycle 0 -> `mem_req` at cycle 1.
- Zero-wait ack at cycle 1 -> `done`/`rdata` at cycle 2, `busy` low at cycle 2.
- Ack at cycle k -> `done` at k+1.
- Check fault: `done`+`fault` at cycle 1; `mem_req` never asserts.
- Timeout: `mem_req` high for exactly `TIMEOUT` cycles; `done`+`fault` next cycle.
- Back-to-back: a new start is accepted in the cycle after DONE.

## Structure
- Shared package: funct3 size codes (`LSU_B`, `LSU_H`, `LSU_W`, `LSU_BU`, `LSU_HU`), state enum, byte-enable width constant.
- Counter width `$clog2(TIMEOUT+1)`.
- One combinational sub-module `lsu_align` generates byte enables and store replication and performs load lane extraction and extension. The FSM lives in the top module.

## Test plan
- LW, addr 0x100, ack in cycle 1, `mem_rdata`=0xDEADBEEF -> `rdata`=0xDEADBEEF at cycle 2, `mem_be`=1111, `busy` high for cycles 0-1.
- LB/LBU at addr 0x103, `mem_rdata`=0x80112233 -> LB `rdata`=0xFFFFFF80; LBU `rdata`=0x00000080.
- SH at addr 0x102, `wdata`=0x0000ABCD, ack after 3 waits -> `mem_be`=1100, `mem_wdata`=0xABCDABCD held stable, `done` at cycle 5.
- LW at addr 0x101 -> `done`+`fault` at cycle 1, no `mem_req`, `rdata` unchanged.
- TIMEOUT=4, no ack -> `mem_req` high for cycles 1-4, `done`+`fault` at cycle 5.
- Reset asserted during REQ, then ack -> `mem_req` 0 next edge, `done` never pulses, `rdata` 0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared access-size codes, FSM states and legality check for the load/store unit
package load_store_unit_pkg;

    localparam int BE_W = 4;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    // Legal size code for the direction, and address aligned to the access size.
    function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] a, input logic is_store);
        logic ok;
        ok = 1'b1;
        if (f3[1:0] == 2'b11 || f3 == 3'b110) ok = 1'b0;
        if (is_store && f3[2]) ok = 1'b0;
        if ((f3 == LSU_H || f3 == LSU_HU) && a[0]) ok = 1'b0;
        if (f3 == LSU_W && a != 2'b00) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// rtl/load_store_unit_align.sv - byte-enable generation, store lane replication and load lane extraction/extension
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [31:0]     wdata_i,
    input  logic [31:0]     mem_rdata_i,
    output logic [BE_W-1:0] be_o,
    output logic [31:0]     wdata_o,
    output logic [31:0]     rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    // Pick the addressed lane, then size the enables/data by the access width.
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = mem_rdata_i[7:0];
            2'd1:    byte_sel = mem_rdata_i[15:8];
            2'd2:    byte_sel = mem_rdata_i[23:16];
            default: byte_sel = mem_rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        sext     = ~funct3_i[2];

        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = mem_rdata_i;
        case (funct3_i)
            LSU_B, LSU_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sext & byte_sel[7]}}, byte_sel};
            end
            LSU_H, LSU_HU: begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sext & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multicycle req/ack data-memory access unit with alignment and timeout faults
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start_rd,
    input  logic            start_wr,
    input  logic [2:0]      funct3,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic            busy,
    output logic            done,
    output logic            fault,
    output logic [31:0]     rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic [BE_W-1:0] mem_be,
    input  logic            mem_ack,
    input  logic [31:0]     mem_rdata
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_e       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [BE_W-1:0]  be_w;
    logic [31:0]      wdata_rep;
    logic [31:0]      rdata_ext;

    lsu_align u_align (
        .funct3_i    (funct3_q),
        .addr_lo_i   (addr_q[1:0]),
        .wdata_i     (wdata_q),
        .mem_rdata_i (mem_rdata),
        .be_o        (be_w),
        .wdata_o     (wdata_rep),
        .rdata_o     (rdata_ext)
    );

    // State and latched access registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            fault_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next-state: accept a start in IDLE, wait for ack or timeout in REQ, pulse DONE.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rd || start_wr) begin
                    addr_d   = addr;
                    wdata_d  = wdata;
                    funct3_d = funct3;
                    we_d     = start_wr;
                    cnt_d    = '0;
                    if ((start_rd && start_wr) || !access_ok(funct3, addr[1:0], start_wr)) begin
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        fault_d = 1'b0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    if (!we_q) rdata_d = rdata_ext;
                    state_d = ST_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_rep;
    assign mem_be    = mem_req ? be_w : '0;
    assign busy      = ((state_q == ST_IDLE) && (start_rd || start_wr)) || mem_req;
    assign done      = (state_q == ST_DONE);
    assign fault     = fault_q;
    assign rdata     = rdata_q;

endmodule
